// File: rtl/fir_pkg.sv
// Shared constants and controller state encoding for the FIR coefficient/sample front end.
package fir_pkg;

  localparam int NUM_TAPS    = 33;
  localparam int COEFF_W     = 16;
  localparam int SAMPLE_W    = 3;
  localparam int DIV_RATIO   = 12;
  localparam int ADDR_W      = 6;
  localparam int COEFF_BUS_W = NUM_TAPS * COEFF_W;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/fir_sample_timer.sv
// Sample-rate divider producing the accumulate strobe and the registered FIR input sample.
module fir_sample_timer
  import fir_pkg::*;
#(
  parameter int DIV_RATIO = fir_pkg::DIV_RATIO,
  parameter int SAMPLE_W  = fir_pkg::SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       run,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic                       en_acc,
  output logic signed [SAMPLE_W-1:0] fir_in,
  output logic                       boundary
);

  localparam int CNT_W = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_RATIO - 1);

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       en_acc_q, en_acc_d;
  logic signed [SAMPLE_W-1:0] fir_in_q, fir_in_d;

  always_comb begin
    cnt_d    = cnt_q;
    en_acc_d = 1'b0;
    fir_in_d = fir_in_q;
    boundary = run && (cnt_q == CNT_LAST);
    if (run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        en_acc_d = 1'b1;
        fir_in_d = sample_in;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      en_acc_q <= 1'b0;
      fir_in_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      en_acc_q <= en_acc_d;
      fir_in_q <= fir_in_d;
    end
  end

  assign en_acc = en_acc_q;
  assign fir_in = fir_in_q;

endmodule

// File: rtl/fir_coeff_sample_ctrl.sv
// Coefficient shadow/active banks with valid/ready write port and sample-aligned atomic commit.
//   state   | meaning
//   ST_IDLE | accepting writes and commits (oWrReady=1)
//   ST_PEND | commit accepted, waiting for sample boundary (or next edge if not running)
module fir_coeff_sample_ctrl
  import fir_pkg::*;
#(
  parameter int NUM_TAPS  = fir_pkg::NUM_TAPS,
  parameter int COEFF_W   = fir_pkg::COEFF_W,
  parameter int SAMPLE_W  = fir_pkg::SAMPLE_W,
  parameter int DIV_RATIO = fir_pkg::DIV_RATIO,
  parameter int ADDR_W    = fir_pkg::ADDR_W
) (
  input  logic                          iClk_12M,
  input  logic                          iRsn,
  input  logic                          iRun,
  input  logic signed [SAMPLE_W-1:0]    iSampleIn,
  input  logic                          iWrValid,
  output logic                          oWrReady,
  input  logic [ADDR_W-1:0]             iWrAddr,
  input  logic signed [COEFF_W-1:0]     iWrData,
  input  logic                          iCommit,
  output logic                          oCommitDone,
  output logic                          oWrErr,
  output logic                          oEnAcc,
  output logic signed [SAMPLE_W-1:0]    oFirIn,
  output logic [NUM_TAPS*COEFF_W-1:0]   oCoeff
);

  logic signed [COEFF_W-1:0] shadow_q [NUM_TAPS];
  logic signed [COEFF_W-1:0] shadow_d [NUM_TAPS];
  logic signed [COEFF_W-1:0] active_q [NUM_TAPS];
  logic signed [COEFF_W-1:0] active_d [NUM_TAPS];
  ctrl_state_e state_q, state_d;
  logic        wr_ready_q, wr_ready_d;
  logic        commit_done_q, commit_done_d;
  logic        wr_err_q, wr_err_d;
  logic        boundary;
  logic        wr_fire, commit_fire;

  fir_sample_timer #(
    .DIV_RATIO (DIV_RATIO),
    .SAMPLE_W  (SAMPLE_W)
  ) u_timer (
    .clk       (iClk_12M),
    .rst_n     (iRsn),
    .run       (iRun),
    .sample_in (iSampleIn),
    .en_acc    (oEnAcc),
    .fir_in    (oFirIn),
    .boundary  (boundary)
  );

  assign wr_fire     = iWrValid && wr_ready_q;
  assign commit_fire = iCommit && wr_ready_q;

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    state_d       = state_q;
    wr_ready_d    = wr_ready_q;
    commit_done_d = 1'b0;
    wr_err_d      = wr_err_q;
    case (state_q)
      ST_IDLE: begin
        wr_ready_d = 1'b1;
        if (wr_fire) begin
          if (iWrAddr < ADDR_W'(NUM_TAPS)) shadow_d[iWrAddr] = iWrData;
          else wr_err_d = 1'b1;
        end
        if (commit_fire) begin
          state_d    = ST_PEND;
          wr_ready_d = 1'b0;
        end
      end
      ST_PEND: begin
        wr_ready_d = 1'b0;
        // Swapping on the strobe edge keeps one coefficient set per sample.
        if (!iRun || boundary) begin
          active_d      = shadow_q;
          commit_done_d = 1'b1;
          wr_err_d      = 1'b0;
          state_d       = ST_IDLE;
          wr_ready_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (!iRsn) begin
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      state_q       <= ST_IDLE;
      wr_ready_q    <= 1'b0;
      commit_done_q <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      state_q       <= state_d;
      wr_ready_q    <= wr_ready_d;
      commit_done_q <= commit_done_d;
      wr_err_q      <= wr_err_d;
    end
  end

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_flat
    assign oCoeff[k*COEFF_W +: COEFF_W] = active_q[k];
  end

  assign oWrReady    = wr_ready_q;
  assign oCommitDone = commit_done_q;
  assign oWrErr      = wr_err_q;

endmodule

// File: tb/tb_fir_coeff_sample_ctrl.sv
// Scoreboard bench: expected strobes and commits are queued at stimulus time and checked on output.
module tb_fir_coeff_sample_ctrl;
  import fir_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rsn, run, wr_valid, commit;
  logic [SAMPLE_W-1:0]    samp;
  logic [ADDR_W-1:0]      wr_addr;
  logic [COEFF_W-1:0]     wr_data;
  logic                   wr_ready, commit_done, wr_err, en_acc;
  logic [SAMPLE_W-1:0]    fir_in;
  logic [COEFF_BUS_W-1:0] coeff;

  fir_coeff_sample_ctrl dut (
    .iClk_12M    (clk),
    .iRsn        (rsn),
    .iRun        (run),
    .iSampleIn   (samp),
    .iWrValid    (wr_valid),
    .oWrReady    (wr_ready),
    .iWrAddr     (wr_addr),
    .iWrData     (wr_data),
    .iCommit     (commit),
    .oCommitDone (commit_done),
    .oWrErr      (wr_err),
    .oEnAcc      (en_acc),
    .oFirIn      (fir_in),
    .oCoeff      (coeff)
  );

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [COEFF_BUS_W-1:0] got, input logic [COEFF_BUS_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct { int edge_n; logic [SAMPLE_W-1:0] val; } samp_exp_t;
  typedef struct { int edge_n; logic [COEFF_BUS_W-1:0] bus; bit with_acc; } com_exp_t;
  samp_exp_t samp_q[$];
  com_exp_t  com_q[$];

  logic [COEFF_W-1:0] mdl_shadow [NUM_TAPS];
  bit  gen_en = 1'b0;
  int  base_n = 0;

  function automatic logic [COEFF_BUS_W-1:0] pack_bus();
    logic [COEFF_BUS_W-1:0] r;
    for (int k = 0; k < NUM_TAPS; k++) r[k*COEFF_W +: COEFF_W] = mdl_shadow[k];
    return r;
  endfunction

  // Sample generator and output monitor share one process.
  int  next_exp = 0;
  int  armed_base = -1;
  bit  first_samp = 1'b0;
  logic [SAMPLE_W-1:0] last_samp = '0;
  samp_exp_t se;
  com_exp_t  ce;
  always @(negedge clk) begin
    if (gen_en) begin
      if (armed_base != base_n) begin
        armed_base = base_n;
        next_exp   = base_n + DIV_RATIO;
        first_samp = 1'b1;
      end
      if (ecnt == next_exp - 1) begin
        samp       = first_samp ? 3'b101 : 3'($urandom);
        first_samp = 1'b0;
        last_samp  = samp;
        samp_q.push_back('{next_exp, samp});
        next_exp  += DIV_RATIO;
      end
    end
    if (en_acc) begin
      if (samp_q.size() == 0) chk("unexpected_en_acc", en_acc, 1'b0);
      else begin
        se = samp_q.pop_front();
        chk("en_acc_edge", ecnt, se.edge_n);
        chk("fir_in", fir_in, se.val);
      end
    end
    if (commit_done) begin
      if (com_q.size() == 0) chk("unexpected_done", commit_done, 1'b0);
      else begin
        ce = com_q.pop_front();
        chk("done_edge", ecnt, ce.edge_n);
        chk("coeff_bus", coeff, ce.bus);
        if (ce.with_acc) chk("swap_with_en_acc", en_acc, 1'b1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    gen_en = 1'b0; rsn = 1'b0; run = 1'b0;
    wr_valid = 1'b0; commit = 1'b0; wr_addr = '0; wr_data = '0;
    tick(2);
    com_q.delete();
    for (int k = 0; k < NUM_TAPS; k++) mdl_shadow[k] = '0;
  endtask

  task automatic release_rst(input bit r);
    rsn = 1'b1; run = r; base_n = ecnt; gen_en = r;
  endtask

  task automatic xfer(input logic [ADDR_W-1:0] a, input logic [COEFF_W-1:0] d,
                      input bit wr, input bit cm, output int acc_edge);
    wr_valid = wr; commit = cm; wr_addr = a; wr_data = d;
    acc_edge = -1;
    for (int i = 0; i < 60; i++) begin
      if (wr_ready) begin
        @(negedge clk);
        acc_edge = ecnt;
        break;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0; commit = 1'b0;
    if (acc_edge < 0) chk("handshake_timeout", wr_ready, 1'b1);
    else if (wr && a < NUM_TAPS) mdl_shadow[a] = d;
  endtask

  task automatic expect_commit(input int a);
    int p;
    if (run) p = base_n + DIV_RATIO * ((a - base_n) / DIV_RATIO + 1);
    else     p = a + 1;
    com_q.push_back('{p, pack_bus(), run});
    if (p > a + 1) begin
      tick(1);
      chk("ready_low_pend", wr_ready, 1'b0);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (commit_done) begin seen = 1'b1; break; end
    end
    if (!seen) chk("done_timeout", commit_done, 1'b1);
    else chk("ready_after_swap", wr_ready, 1'b1);
  endtask

  initial begin
    int a;
    bit seen;
    do_reset();
    chk("rst_ready", wr_ready, 1'b0);
    chk("rst_en_acc", en_acc, 1'b0);
    chk("rst_fir_in", fir_in, '0);
    chk("rst_coeff", coeff, '0);
    chk("rst_done", commit_done, 1'b0);
    chk("rst_err", wr_err, 1'b0);

    release_rst(1'b1);
    tick(1);
    chk("ready_first_edge", wr_ready, 1'b1);
    tick(26);
    chk("coeff_still_zero", coeff, '0);

    xfer(6'd0,  16'h0100, 1'b1, 1'b0, a);
    xfer(6'd32, 16'hFF00, 1'b1, 1'b0, a);
    xfer(6'd0,  16'h0000, 1'b0, 1'b1, a);
    expect_commit(a);
    wait_done();
    chk("tap0", coeff[15:0], 16'h0100);
    chk("tap32", coeff[527:512], 16'hFF00);

    xfer(6'd5, 16'h7FFF, 1'b1, 1'b1, a);
    expect_commit(a);
    wait_done();
    chk("tap5_same_cycle", coeff[95:80], 16'h7FFF);

    xfer(6'd40, 16'h1234, 1'b1, 1'b0, a);
    chk("wr_err_set", wr_err, 1'b1);
    xfer(6'd0, 16'h0000, 1'b0, 1'b1, a);
    expect_commit(a);
    wait_done();
    chk("wr_err_cleared", wr_err, 1'b0);

    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (en_acc) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    if (!seen) chk("pulse_timeout", en_acc, 1'b1);
    run = 1'b0; gen_en = 1'b0;
    tick(3);
    chk("fir_in_hold", fir_in, last_samp);
    xfer(6'd1, 16'h0002, 1'b1, 1'b0, a);
    xfer(6'd0, 16'h0000, 1'b0, 1'b1, a);
    expect_commit(a);
    wait_done();
    chk("tap1_stopped", coeff[31:16], 16'h0002);
    tick(15);
    chk("en_acc_stopped", en_acc, 1'b0);

    do_reset();
    release_rst(1'b1);
    tick(DIV_RATIO + 1);
    xfer(6'd3, 16'h5555, 1'b1, 1'b0, a);
    xfer(6'd0, 16'h0000, 1'b0, 1'b1, a);
    gen_en = 1'b0; rsn = 1'b0;
    tick(1);
    for (int k = 0; k < NUM_TAPS; k++) mdl_shadow[k] = '0;
    chk("midrst_coeff", coeff, '0);
    chk("midrst_ready", wr_ready, 1'b0);
    chk("midrst_done", commit_done, 1'b0);
    release_rst(1'b1);
    tick(1);
    chk("midrst_ready_back", wr_ready, 1'b1);
    tick(DIV_RATIO);
    xfer(6'd0, 16'h0000, 1'b0, 1'b1, a);
    expect_commit(a);
    wait_done();
    chk("shadow_discarded", coeff, '0);

    gen_en = 1'b0;
    tick(3);
    chk("samp_q_drained", samp_q.size(), 0);
    chk("com_q_drained", com_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
